// File: rtl/div_radix2_pkg.sv
// Shared divider definitions: FSM state encodings and latency figures that the
// hazard unit and E-stage hilo logic reference by the same names.
package div_radix2_pkg;

    // 2-bit divider FSM encoding.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } divState_t;

    // Cycles from accept to the ready pulse for a normal divide.
    localparam int DIV_LATENCY = 33;

    // Cycles from accept to the ready pulse for a divide-by-zero.
    localparam int DIV_ZERO_LATENCY = 2;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference when it does not
// go negative.
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] partRem,
    input  logic             dividendBit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext,
    output logic             qBit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Trial subtract in WIDTH+1 bits; the top bit is the borrow / sign.
    // The partial remainder is always below the divisor, so whichever value is
    // kept fits back into WIDTH bits.
    always_comb begin
        shifted = {partRem, dividendBit};
        trial   = shifted - {1'b0, divisor};
        qBit    = ~trial[WIDTH];
        remNext = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU. Works on operand
// magnitudes and fixes up signs on the final step. Drives the E-stage divider
// stall and presents {remainder, quotient} in the cycle the stall drops.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic               div_annul,
    input  logic [WIDTH-1:0]   div_a,
    input  logic [WIDTH-1:0]   div_b,
    output logic               div_stall,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] div_result
);

    // Two's complement negate when requested; also used to form magnitudes.
    function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v,
                                               input logic             neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // Magnitude of an operand; unsigned operands pass through unchanged.
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v,
                                                input logic             isSigned);
        return negIf(v, isSigned & v[WIDTH-1]);
    endfunction

    divState_t          state;
    divState_t          stateNext;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   remReg;
    logic [WIDTH-1:0]   quoReg;
    logic [WIDTH-1:0]   divisorReg;
    logic               signQ;
    logic               signR;
    logic [2*WIDTH-1:0] resultStage;
    logic [2*WIDTH-1:0] resultHeld;

    logic               accept;
    logic               abort;
    logic               lastStep;
    logic [WIDTH-1:0]   stepRem;
    logic               stepQ;
    logic [WIDTH-1:0]   quoShift;

    // quoReg starts as the dividend magnitude; its MSB feeds each step while
    // quotient bits shift in at the bottom, so after WIDTH steps it holds the
    // quotient.
    div_radix2_step #(
        .WIDTH(WIDTH)
    ) uStep (
        .partRem    (remReg),
        .dividendBit(quoReg[WIDTH-1]),
        .divisor    (divisorReg),
        .remNext    (stepRem),
        .qBit       (stepQ)
    );

    // Control qualifiers shared by next-state and datapath logic.
    always_comb begin
        accept   = (state == DIV_IDLE) & div_start & ~div_annul;
        abort    = div_annul | ~div_start;
        lastStep = (count == CNT_W'(WIDTH - 1));
        quoShift = {quoReg[WIDTH-2:0], stepQ};
    end

    // Next-state logic; any busy state falls back to IDLE on abort.
    always_comb begin
        stateNext = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    stateNext = (div_b == '0) ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                stateNext = abort ? DIV_IDLE : DIV_END;
            end
            DIV_ON: begin
                if (abort) begin
                    stateNext = DIV_IDLE;
                end else if (lastStep) begin
                    stateNext = DIV_END;
                end
            end
            DIV_END: begin
                stateNext = DIV_IDLE;
            end
            default: begin
                stateNext = DIV_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Operand capture, iteration, sign fixup and result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count       <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            divisorReg  <= '0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            resultStage <= '0;
            resultHeld  <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        count      <= '0;
                        remReg     <= '0;
                        quoReg     <= absVal(div_a, div_signed);
                        divisorReg <= absVal(div_b, div_signed);
                        signQ      <= div_signed & (div_a[WIDTH-1] ^ div_b[WIDTH-1]);
                        signR      <= div_signed & div_a[WIDTH-1];
                    end
                end
                DIV_ON: begin
                    remReg <= stepRem;
                    quoReg <= quoShift;
                    count  <= count + CNT_W'(1);
                    if (lastStep) begin
                        resultStage <= {negIf(stepRem, signR), negIf(quoShift, signQ)};
                    end
                end
                DIV_ZERO: begin
                    // Re-applying the dividend sign to its magnitude gives back
                    // the original dividend as the remainder.
                    resultStage <= {negIf(quoReg, signR), {WIDTH{1'b1}}};
                end
                DIV_END: begin
                    if (div_ready) begin
                        resultHeld <= resultStage;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Ready pulses in END unless the operation is annulled or dropped that
    // cycle; the new result is visible during the pulse and held afterwards.
    always_comb begin
        div_ready  = (state == DIV_END) & ~abort;
        div_result = div_ready ? resultStage : resultHeld;
        div_stall  = div_start & ~div_ready & ~div_annul;
    end

endmodule
